// File: rtl/split_search_driver.sv
// Pseudo-random candidate generator driving a combinational split constraint checker.
// Optional `SPLIT_DRV_CONTINUE_EN: count every hit and keep searching until the budget runs out.
module split_search_driver #(
  parameter int unsigned VEC_W  = 779,
  parameter int unsigned LFSR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic [CNT_W-1:0]   max_tries,
  input  logic               sat_in,
  output logic [VEC_W-1:0]   cand,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [CNT_W-1:0]   tries,
`ifdef SPLIT_DRV_CONTINUE_EN
  output logic [CNT_W-1:0]   hit_cnt,
`endif
  output logic [VEC_W-1:0]   witness
);

  localparam int unsigned WORDS = (VEC_W + LFSR_W - 1) / LFSR_W;
  localparam int unsigned WC_W  = $clog2(WORDS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // x^64+x^63+x^61+x^60+1 as a right-shifting Galois feedback mask
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(64'hD800_0000_0000_0000);

  logic [1:0]        state, state_next;
  logic [LFSR_W-1:0] lfsr, lfsr_next;
  logic [CNT_W-1:0]  budget, budget_next;
  logic [WC_W-1:0]   wcnt, wcnt_next;
  logic [VEC_W-1:0]  cand_next, witness_next;
  logic [CNT_W-1:0]  tries_next, tries_inc;
  logic              found_next;
  logic              idle_like;
`ifdef SPLIT_DRV_CONTINUE_EN
  logic [CNT_W-1:0]  hit_next;
`endif

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ ({LFSR_W{v[0]}} & TAPS);
  endfunction

  // State register and all registered outputs; busy/done follow the state one cycle late
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lfsr    <= LFSR_W'(1);
      budget  <= '0;
      wcnt    <= '0;
      cand    <= '0;
      witness <= '0;
      tries   <= '0;
      found   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SPLIT_DRV_CONTINUE_EN
      hit_cnt <= '0;
`endif
    end else begin
      state   <= state_next;
      lfsr    <= lfsr_next;
      budget  <= budget_next;
      wcnt    <= wcnt_next;
      cand    <= cand_next;
      witness <= witness_next;
      tries   <= tries_next;
      found   <= found_next;
      busy    <= (state == S_FILL) || (state == S_CHECK);
      done    <= (state == S_DONE);
`ifdef SPLIT_DRV_CONTINUE_EN
      hit_cnt <= hit_next;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_next   = state;
    lfsr_next    = lfsr;
    budget_next  = budget;
    wcnt_next    = wcnt;
    cand_next    = cand;
    witness_next = witness;
    tries_next   = tries;
    found_next   = found;
`ifdef SPLIT_DRV_CONTINUE_EN
    hit_next     = hit_cnt;
`endif
    idle_like = ((state == S_IDLE) || (state == S_DONE)) && !busy;
    tries_inc = (&tries) ? tries : tries + CNT_W'(1);

    // A seed loaded alongside start is the one the new run uses
    if (idle_like && seed_load)
      lfsr_next = (seed == '0) ? LFSR_W'(1) : seed;

    case (state)
      S_IDLE, S_DONE: begin
        if (idle_like && start) begin
          tries_next   = '0;
          found_next   = 1'b0;
          witness_next = '0;
          budget_next  = max_tries;
          wcnt_next    = '0;
`ifdef SPLIT_DRV_CONTINUE_EN
          hit_next     = '0;
`endif
          state_next   = (max_tries == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        // Current LFSR word enters at the top; oldest bits fall off the bottom
        cand_next = {lfsr, cand[VEC_W-1:LFSR_W]};
        lfsr_next = lfsr_step(lfsr);
        if (wcnt == WC_W'(WORDS - 1)) begin
          wcnt_next  = '0;
          state_next = S_CHECK;
        end else begin
          wcnt_next = wcnt + WC_W'(1);
        end
      end
      S_CHECK: begin
        tries_next = tries_inc;
`ifdef SPLIT_DRV_CONTINUE_EN
        if (sat_in) begin
          if (!(&hit_cnt)) hit_next = hit_cnt + CNT_W'(1);
          if (!found) begin
            witness_next = cand;
            found_next   = 1'b1;
          end
        end
        state_next = (tries_inc == budget) ? S_DONE : S_FILL;
`else
        if (sat_in) begin
          witness_next = cand;
          found_next   = 1'b1;
          state_next   = S_DONE;
        end else if (tries_inc == budget) begin
          state_next = S_DONE;
        end else begin
          state_next = S_FILL;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_split_search_driver.sv
// Scoreboard bench for split_search_driver: a run-level reference model predicts each
// run's result; a monitor compares when done rises.
module tb_split_search_driver;

  localparam int unsigned VW    = 779;
  localparam int unsigned LW    = 64;
  localparam int unsigned CW    = 32;
  localparam int unsigned NW    = (VW + LW - 1) / LW;
  localparam int unsigned TRY_C = NW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          seed_load = 1'b0;
  logic [LW-1:0] seed = '0;
  logic [CW-1:0] max_tries = '0;
  logic          sat_in;
  logic [VW-1:0] cand;
  logic          busy, done, found;
  logic [CW-1:0] tries;
  logic [VW-1:0] witness;
`ifdef SPLIT_DRV_CONTINUE_EN
  logic [CW-1:0] hit_cnt;
`endif

  int unsigned thresh = 0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic          done_prev = 1'b0;
  logic [LW-1:0] m_lfsr = 64'h1;

  typedef struct {
    logic          found;
    logic [CW-1:0] tries;
    logic [CW-1:0] hits;
    logic [VW-1:0] witness;
    logic [VW-1:0] cand;
    int            lat;
    int            start_edge;
  } exp_t;
  exp_t q[$];

  split_search_driver dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
    .max_tries(max_tries), .sat_in(sat_in), .cand(cand), .busy(busy), .done(done),
    .found(found), .tries(tries),
`ifdef SPLIT_DRV_CONTINUE_EN
    .hit_cnt(hit_cnt),
`endif
    .witness(witness));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Stub checker: a candidate satisfies when its low byte is below the threshold
  function automatic logic sat_of(input logic [VW-1:0] c, input int unsigned th);
    return 32'(c[7:0]) < th;
  endfunction
  assign sat_in = sat_of(cand, thresh);

  // Multiply-by-x^-1 modulo the feedback polynomial, built from its exponent list
  function automatic logic [LW-1:0] poly_next(input logic [LW-1:0] v);
    int exps[4] = '{64, 63, 61, 60};
    logic [LW-1:0] m = '0;
    foreach (exps[i]) m[exps[i]-1] = 1'b1;
    return v[0] ? ((v >> 1) ^ m) : (v >> 1);
  endfunction

  // One candidate = the last VW bits of NW consecutive generator words, oldest word lowest
  function automatic logic [VW-1:0] next_cand();
    logic [NW*LW-1:0] full;
    for (int i = 0; i < int'(NW); i++) begin
      full[i*LW +: LW] = m_lfsr;
      m_lfsr = poly_next(m_lfsr);
    end
    return full[NW*LW-1 -: VW];
  endfunction

  function automatic exp_t model_run(input int unsigned budget, input int unsigned th);
    exp_t e;
    logic [VW-1:0] c;
    e.found = 1'b0; e.tries = '0; e.hits = '0; e.witness = '0; e.cand = cand; e.start_edge = 0;
    for (int unsigned t = 1; t <= budget; t++) begin
      c = next_cand();
      e.cand  = c;
      e.tries = CW'(t);
      if (sat_of(c, th)) begin
        e.hits = e.hits + 1;
        if (!e.found) begin
          e.found = 1'b1;
          e.witness = c;
        end
`ifndef SPLIT_DRV_CONTINUE_EN
        break;
`endif
      end
    end
    e.lat = 1 + int'(TRY_C) * int'(e.tries);
    return e;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare the oldest prediction whenever done rises
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done && !done_prev) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = q.pop_front();
        chk("found",   VW'(found),   VW'(e.found));
        chk("tries",   VW'(tries),   VW'(e.tries));
        chk("witness", witness,      e.witness);
        chk("cand",    cand,         e.cand);
        chk("latency", VW'(cyc - e.start_edge), VW'(e.lat));
`ifdef SPLIT_DRV_CONTINUE_EN
        chk("hit_cnt", VW'(hit_cnt), VW'(e.hits));
`endif
      end
    end
    done_prev = rst ? 1'b0 : done;
  end

  task automatic do_run(input int unsigned budget, input int unsigned th, input bit sld,
                        input logic [LW-1:0] sv, input bit inject);
    exp_t e;
    @(negedge clk);
    thresh = th; max_tries = CW'(budget); start = 1'b1; seed_load = sld; seed = sv;
    if (sld) m_lfsr = (sv == '0) ? LW'(1) : sv;
    e = model_run(budget, th);
    e.start_edge = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    if (budget == 0) begin
      for (int k = 0; k < 3; k++) begin
        chk("busy_zero_budget", VW'(busy), VW'(0));
        @(negedge clk);
      end
    end else if (inject) begin
      // start/seed pulses while busy must leave the run untouched
      repeat (2) @(negedge clk);
      start = 1'b1; seed_load = 1'b1; seed = {$urandom, $urandom}; max_tries = CW'(1);
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0;
    end
    for (int k = 0; k < int'(budget * TRY_C) + 40 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL timeout actual=pending required=done");
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_cand",    cand,    '0);
      chk("rst_witness", witness, '0);
      chk("rst_flags",   VW'({busy, done, found}), VW'(0));
      chk("rst_tries",   VW'(tries), VW'(0));
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", VW'({busy, done}), VW'(0));

    do_run(0, 0, 1'b0, '0, 1'b0);            // zero budget
    do_run(5, 256, 1'b1, 64'h1, 1'b0);       // immediate hit from seed 1
    do_run(3, 0, 1'b0, '0, 1'b1);            // budget exhaustion, busy pulses ignored
    do_run(2, 0, 1'b1, 64'h0, 1'b0);         // seed 0 behaves as seed 1
    do_run(2, 0, 1'b1, 64'h1, 1'b0);

    // Reset mid-FILL aborts; next run starts from the reset LFSR
    @(negedge clk);
    max_tries = CW'(3); thresh = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_cand",  cand, '0);
    chk("abort_flags", VW'({busy, done, found}), VW'(0));
    chk("abort_tries", VW'(tries), VW'(0));
    @(negedge clk);
    rst = 1'b0; m_lfsr = 64'h1;
    do_run(2, 128, 1'b0, '0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int unsigned b, th;
      b  = $urandom_range(1, 6);
      th = ($urandom_range(0, 3) == 0) ? 256 : $urandom_range(0, 60);
      do_run(b, th, $urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
